// File: rtl/render_queue_ctrl_pkg.sv
// Shared types and constants for the render queue controller.
package render_queue_ctrl_pkg;

  localparam logic [7:0] VGA_DO_RENDER = 8'hFF;

  typedef struct packed {
    logic [7:0]  magic;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } render_cmd_t;

  localparam render_cmd_t DO_RENDER_CMD = '{magic: VGA_DO_RENDER, x: 16'h0, y: 16'h0, flags: 8'h0};

  localparam logic [2:0] REG_CMD_LO  = 3'd0;
  localparam logic [2:0] REG_X       = 3'd1;
  localparam logic [2:0] REG_Y_PUSH  = 3'd2;
  localparam logic [2:0] REG_COMMIT  = 3'd3;
  localparam logic [2:0] REG_CLEAR   = 3'd4;

endpackage

// File: rtl/render_queue_ctrl_cmd_bank.sv
// One command list bank: synchronous write, combinational read, no reset on storage.
module render_cmd_bank
  import render_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW-1:0] waddr,
  input  render_cmd_t wdata,
  input  logic [AW-1:0] raddr,
  output render_cmd_t rdata
);

  render_cmd_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/render_queue_ctrl.sv
// Double-banked frame scheduler: CPU fills the write bank, the consumer replays the
// read bank every frame, and a committed list swaps in on the DO_RENDER pop.
module render_queue_ctrl
  import render_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front,
  output logic        frame_swapped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  render_cmd_t   stage_q, stage_d;
  logic [15:0]   readdata_q, readdata_d;
  render_cmd_t   dout_q, dout_d;
  logic          frame_swapped_q, frame_swapped_d;

  logic          push_ok;
  render_cmd_t   push_word;
  render_cmd_t   rdata0, rdata1, head_sel;

  render_cmd_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk50),
    .we    (push_ok & rd_bank_q),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (push_word),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (rdata0)
  );

  render_cmd_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk50),
    .we    (push_ok & ~rd_bank_q),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (push_word),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (rdata1)
  );

  // Head is looked up from next-state pointers so dout tracks every pointer/bank change.
  assign head_sel = rd_bank_d ? rdata1 : rdata0;
  assign dout_d   = (rd_ptr_d < rd_cnt_d) ? head_sel : DO_RENDER_CMD;

  always_comb begin
    rd_bank_d       = rd_bank_q;
    rd_ptr_d        = rd_ptr_q;
    rd_cnt_d        = rd_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    pending_d       = pending_q;
    overflow_d      = overflow_q;
    frame_cnt_d     = frame_cnt_q;
    stage_d         = stage_q;
    readdata_d      = readdata_q;
    frame_swapped_d = 1'b0;
    push_ok         = 1'b0;
    push_word       = '{magic: stage_q.magic, x: stage_q.x, y: writedata, flags: stage_q.flags};

    if (render_queue_pop_front) begin
      if (rd_ptr_q < rd_cnt_q) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end else begin
        rd_ptr_d    = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (pending_q) begin
          rd_bank_d       = ~rd_bank_q;
          rd_cnt_d        = wr_cnt_q;
          wr_cnt_d        = '0;
          pending_d       = 1'b0;
          frame_swapped_d = 1'b1;
        end
      end
    end

    // Applied after the swap so a same-cycle commit re-arms pending for the next frame.
    if (chipselect && write) begin
      case (address)
        REG_CMD_LO: begin
          stage_d.magic = writedata[7:0];
          stage_d.flags = writedata[15:8];
        end
        REG_X: stage_d.x = writedata;
        REG_Y_PUSH: begin
          stage_d.y = writedata;
          if (!pending_q && (wr_cnt_q < DEPTH_C)) begin
            push_ok  = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        REG_COMMIT: if (writedata[0]) pending_d = 1'b1;
        REG_CLEAR: begin
          if (!pending_q) begin
            wr_cnt_d   = '0;
            overflow_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (chipselect && read) begin
      case (address)
        3'd0:    readdata_d = {pending_q, overflow_q, 6'b0, 8'(wr_cnt_q)};
        3'd1:    readdata_d = 16'(rd_cnt_q);
        3'd2:    readdata_d = frame_cnt_q;
        default: readdata_d = 16'h0;
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rd_bank_q       <= 1'b0;
      rd_ptr_q        <= '0;
      rd_cnt_q        <= '0;
      wr_cnt_q        <= '0;
      pending_q       <= 1'b0;
      overflow_q      <= 1'b0;
      frame_cnt_q     <= 16'h0;
      stage_q         <= '0;
      readdata_q      <= 16'h0;
      dout_q          <= DO_RENDER_CMD;
      frame_swapped_q <= 1'b0;
    end else begin
      rd_bank_q       <= rd_bank_d;
      rd_ptr_q        <= rd_ptr_d;
      rd_cnt_q        <= rd_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      pending_q       <= pending_d;
      overflow_q      <= overflow_d;
      frame_cnt_q     <= frame_cnt_d;
      stage_q         <= stage_d;
      readdata_q      <= readdata_d;
      dout_q          <= dout_d;
      frame_swapped_q <= frame_swapped_d;
    end
  end

  assign readdata          = readdata_q;
  assign render_queue_dout = dout_q;
  assign frame_swapped     = frame_swapped_q;

endmodule

// File: tb/tb_render_queue_ctrl.sv
// Scoreboard bench for render_queue_ctrl: expected {swap, word} pairs are queued as
// lists are built/committed and popped as the consumer pops words.
module tb_render_queue_ctrl;

  localparam int DEPTH = 32;
  localparam logic [47:0] DO_W = 48'hFF00_0000_0000;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [15:0] writedata = 16'h0;
  logic [15:0] readdata;
  logic [47:0] render_queue_dout;
  logic        render_queue_pop_front = 1'b0;
  logic        frame_swapped;

  int errors = 0;
  int checks = 0;
  logic [48:0] exp_q[$];

  logic [47:0] cmd_a, cmd_b, cmd_c0, cmd_c1, cmd_c2, cmd_d0, cmd_d1;

  always #10 clk50 = ~clk50;

  render_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (chipselect),
    .write                  (write),
    .read                   (read),
    .address                (address),
    .writedata              (writedata),
    .readdata               (readdata),
    .render_queue_dout      (render_queue_dout),
    .render_queue_pop_front (render_queue_pop_front),
    .frame_swapped          (frame_swapped)
  );

  function automatic logic [47:0] mk(input logic [7:0] m, input logic [15:0] x,
                                     input logic [15:0] y, input logic [7:0] f);
    return {m, x, y, f};
  endfunction

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk50);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk50);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic push_cmd(input logic [47:0] c);
    cpu_write(3'd0, {c[7:0], c[47:40]});
    cpu_write(3'd1, c[39:24]);
    cpu_write(3'd2, c[23:8]);
  endtask

  // Returns the word consumed by the pop and the swap pulse seen the cycle after.
  task automatic pop_word(output logic [47:0] w, output logic sw);
    @(negedge clk50);
    w = render_queue_dout;
    render_queue_pop_front = 1'b1;
    @(negedge clk50);
    render_queue_pop_front = 1'b0;
    sw = frame_swapped;
  endtask

  task automatic test_reset();
    logic [47:0] w; logic sw; logic [48:0] e; logic [15:0] rd;
    reset = 1'b1;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    checks++;
    if (render_queue_dout !== DO_W) begin errors++; $display("FAIL reset_dout: got %h expected %h", render_queue_dout, DO_W); end
    checks++;
    if (readdata !== 16'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, DO_W});
      pop_word(w, sw);
      e = exp_q.pop_front();
      checks++;
      if ({sw, w} !== e) begin errors++; $display("FAIL reset_pop%0d: got %h expected %h", i, {sw, w}, e); end
    end
    cpu_read(3'd2, rd);
    checks++;
    if (rd !== 16'd3) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 3", rd); end
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
  endtask

  task automatic test_swap();
    logic [47:0] w; logic sw; logic [48:0] e; logic [15:0] rd;
    push_cmd(cmd_a);
    push_cmd(cmd_b);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0002) begin errors++; $display("FAIL swap_status_pre: got %h expected 0002", rd); end
    cpu_write(3'd3, 16'h0001);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h8002) begin errors++; $display("FAIL swap_status_pending: got %h expected 8002", rd); end
    exp_q.push_back({1'b1, DO_W});
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back({1'b0, cmd_a});
      exp_q.push_back({1'b0, cmd_b});
      exp_q.push_back({1'b0, DO_W});
    end
    for (int i = 0; i < 7; i++) begin
      pop_word(w, sw);
      e = exp_q.pop_front();
      checks++;
      if ({sw, w} !== e) begin errors++; $display("FAIL swap_pop%0d: got %h expected %h", i, {sw, w}, e); end
    end
    cpu_read(3'd1, rd);
    checks++;
    if (rd !== 16'd2) begin errors++; $display("FAIL swap_rd_cnt: got %0d expected 2", rd); end
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL swap_status_post: got %h expected 0", rd); end
    cpu_read(3'd2, rd);
    checks++;
    if (rd !== 16'd6) begin errors++; $display("FAIL swap_frame_cnt: got %0d expected 6", rd); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] w; logic [48:0] e; logic [15:0] rd;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back({1'b0, cmd_a});
      exp_q.push_back({1'b0, cmd_b});
      exp_q.push_back({1'b0, DO_W});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk50);
      w = render_queue_dout;
      render_queue_pop_front = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if ({1'b0, w} !== e) begin errors++; $display("FAIL b2b_pop%0d: got %h expected %h", i, w, e[47:0]); end
    end
    @(negedge clk50);
    render_queue_pop_front = 1'b0;
    cpu_read(3'd2, rd);
    checks++;
    if (rd !== 16'd8) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 8", rd); end
  endtask

  task automatic test_overflow();
    logic [15:0] rd;
    for (int i = 0; i < DEPTH + 2; i++) push_cmd(mk(8'h10, 16'(i), 16'(i + 1), 8'h0));
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h4020) begin errors++; $display("FAIL ovf_status: got %h expected 4020", rd); end
    cpu_write(3'd4, 16'h0);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL ovf_clear: got %h expected 0", rd); end
  endtask

  task automatic test_pending_drop();
    logic [47:0] w; logic sw; logic [48:0] e; logic [15:0] rd;
    push_cmd(cmd_c0);
    push_cmd(cmd_c1);
    cpu_write(3'd3, 16'h0001);
    push_cmd(cmd_c2);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'hC002) begin errors++; $display("FAIL pend_push_drop: got %h expected C002", rd); end
    cpu_write(3'd4, 16'h0);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'hC002) begin errors++; $display("FAIL pend_clear_ignored: got %h expected C002", rd); end
    exp_q.push_back({1'b0, cmd_a});
    exp_q.push_back({1'b0, cmd_b});
    exp_q.push_back({1'b1, DO_W});
    exp_q.push_back({1'b0, cmd_c0});
    exp_q.push_back({1'b0, cmd_c1});
    exp_q.push_back({1'b0, DO_W});
    for (int i = 0; i < 6; i++) begin
      pop_word(w, sw);
      e = exp_q.pop_front();
      checks++;
      if ({sw, w} !== e) begin errors++; $display("FAIL pend_pop%0d: got %h expected %h", i, {sw, w}, e); end
    end
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h4000) begin errors++; $display("FAIL pend_ovf_kept: got %h expected 4000", rd); end
    cpu_write(3'd4, 16'h0);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL pend_final_clear: got %h expected 0", rd); end
  endtask

  task automatic test_commit_race();
    logic [47:0] w; logic sw; logic [48:0] e; logic [15:0] rd;
    push_cmd(cmd_d0);
    push_cmd(cmd_d1);
    exp_q.push_back({1'b0, cmd_c0});
    exp_q.push_back({1'b0, cmd_c1});
    for (int i = 0; i < 2; i++) begin
      pop_word(w, sw);
      e = exp_q.pop_front();
      checks++;
      if ({sw, w} !== e) begin errors++; $display("FAIL race_pre%0d: got %h expected %h", i, {sw, w}, e); end
    end
    @(negedge clk50);
    w = render_queue_dout;
    render_queue_pop_front = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 3'd3; writedata = 16'h0001;
    @(negedge clk50);
    render_queue_pop_front = 1'b0;
    chipselect = 1'b0; write = 1'b0;
    sw = frame_swapped;
    checks++;
    if ({sw, w} !== {1'b0, DO_W}) begin errors++; $display("FAIL race_no_swap: got %h expected %h", {sw, w}, {1'b0, DO_W}); end
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h8002) begin errors++; $display("FAIL race_pending: got %h expected 8002", rd); end
    exp_q.push_back({1'b0, cmd_c0});
    exp_q.push_back({1'b0, cmd_c1});
    exp_q.push_back({1'b1, DO_W});
    exp_q.push_back({1'b0, cmd_d0});
    for (int i = 0; i < 4; i++) begin
      pop_word(w, sw);
      e = exp_q.pop_front();
      checks++;
      if ({sw, w} !== e) begin errors++; $display("FAIL race_pop%0d: got %h expected %h", i, {sw, w}, e); end
    end
    checks++;
    if (render_queue_dout !== cmd_d1) begin errors++; $display("FAIL race_head: got %h expected %h", render_queue_dout, cmd_d1); end
  endtask

  task automatic test_reset_mid_list();
    logic [47:0] w; logic sw; logic [48:0] e; logic [15:0] rd;
    @(negedge clk50);
    reset = 1'b1;
    #1;
    checks++;
    if (render_queue_dout !== DO_W) begin errors++; $display("FAIL rst_mid_dout: got %h expected %h", render_queue_dout, DO_W); end
    @(negedge clk50);
    reset = 1'b0;
    exp_q.delete();
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL rst_mid_status: got %h expected 0", rd); end
    cpu_read(3'd2, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL rst_mid_frame_cnt: got %h expected 0", rd); end
    cpu_write(3'd3, 16'h0001);
    cpu_read(3'd0, rd);
    checks++;
    if (rd !== 16'h8000) begin errors++; $display("FAIL empty_pending: got %h expected 8000", rd); end
    exp_q.push_back({1'b1, DO_W});
    exp_q.push_back({1'b0, DO_W});
    for (int i = 0; i < 2; i++) begin
      pop_word(w, sw);
      e = exp_q.pop_front();
      checks++;
      if ({sw, w} !== e) begin errors++; $display("FAIL empty_pop%0d: got %h expected %h", i, {sw, w}, e); end
    end
    checks++;
    if (render_queue_dout !== DO_W) begin errors++; $display("FAIL empty_dout: got %h expected %h", render_queue_dout, DO_W); end
    cpu_read(3'd1, rd);
    checks++;
    if (rd !== 16'h0) begin errors++; $display("FAIL empty_rd_cnt: got %0d expected 0", rd); end
  endtask

  initial begin
    cmd_a  = mk(8'd1, 16'd100, 16'd50, 8'd0);
    cmd_b  = mk(8'd2, 16'd200, 16'd60, 8'd1);
    cmd_c0 = mk(8'd3, 16'h1234, 16'h5678, 8'h9A);
    cmd_c1 = mk(8'd4, 16'hBEEF, 16'hCAFE, 8'h55);
    cmd_c2 = mk(8'd5, 16'h0F0F, 16'hF0F0, 8'hAA);
    cmd_d0 = mk(8'd6, 16'h0011, 16'h0022, 8'h33);
    cmd_d1 = mk(8'hFF, 16'h0044, 16'h0055, 8'h66);
    test_reset();
    test_swap();
    test_back_to_back();
    test_overflow();
    test_pending_drop();
    test_commit_race();
    test_reset_mid_list();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
